// File: rtl/feed_rtc_pkg.sv
// Shared types and limits for the feeder real-time clock.
// Alarm record layout matches the 15-bit alarm_data write word.
package feed_rtc_pkg;

    localparam int MAX_SEC      = 59;
    localparam int MAX_MIN      = 59;
    localparam int HOUR12_MIN   = 1;
    localparam int HOUR12_MAX   = 12;
    localparam int HOUR24_MAX   = 23;
    localparam int ALARM_DATA_W = 15;

    typedef struct packed {
        logic       en;
        logic       ampm;
        logic [4:0] hour;
        logic [7:0] min;
    } alarm_t;

    function automatic logic [7:0] inc_wrap(input logic [7:0] v,
                                            input int unsigned max);
        return (v == 8'(max)) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ cycles.
// clear_i restarts the count so the next tick is a full period away.
module rtc_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o || clear_i) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/feed_rtc.sv
// Feeder RTC: hh:mm:ss in 12 h or 24 h mode with feed-schedule alarms.
// Optional RTC_UPTIME_EN adds a 32-bit seconds-since-reset counter.
module feed_rtc
    import feed_rtc_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int MODE_24H   = 0,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_hour,
    input  logic                    set_min,
    input  logic                    set_sec,
    input  logic                    set_ampm,
    input  logic [7:0]              set_data,
    input  logic                    alarm_wr,
    input  logic [SEL_W-1:0]        alarm_sel,
    input  logic [ALARM_DATA_W-1:0] alarm_data,
    output logic [7:0]              hour,
    output logic [7:0]              minute,
    output logic [7:0]              second,
    output logic                    ampm,
    output logic                    sec_tick,
    output logic [NUM_ALARMS-1:0]   alarm_fire,
    output logic [31:0]             uptime
);

    localparam logic [7:0] HOUR_RST = (MODE_24H != 0) ? 8'd0 : 8'd12;

    logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic       ampm_q, ampm_d, tick_q;
    logic [NUM_ALARMS-1:0] fire_q, fire_d;
    alarm_t alarm_q [NUM_ALARMS];
    alarm_t alarm_d [NUM_ALARMS];

    logic       tick;
    logic       sec_ok, min_ok, hour_ok, ampm_ok, any_set;
    logic       carry_min, carry_hr;
    logic [7:0] adv_sec, adv_min, adv_hour;
    logic       adv_ampm;

    rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (sec_ok),
        .tick_o  (tick)
    );

    always_comb begin
        sec_ok  = set_sec && (set_data <= 8'(MAX_SEC));
        min_ok  = set_min && (set_data <= 8'(MAX_MIN));
        if (MODE_24H != 0)
            hour_ok = set_hour && (set_data <= 8'(HOUR24_MAX));
        else
            hour_ok = set_hour && (set_data >= 8'(HOUR12_MIN))
                               && (set_data <= 8'(HOUR12_MAX));
        ampm_ok = set_ampm && (MODE_24H == 0);
        any_set = sec_ok || min_ok || hour_ok || ampm_ok;

        carry_min = tick && (sec_q == 8'(MAX_SEC));
        carry_hr  = carry_min && (min_q == 8'(MAX_MIN));
        adv_sec   = tick ? inc_wrap(sec_q, MAX_SEC) : sec_q;
        adv_min   = carry_min ? inc_wrap(min_q, MAX_MIN) : min_q;
        adv_hour  = hour_q;
        adv_ampm  = ampm_q;
        if (carry_hr) begin
            if (MODE_24H != 0) begin
                adv_hour = inc_wrap(hour_q, HOUR24_MAX);
            end else if (hour_q == 8'(HOUR12_MAX)) begin
                adv_hour = 8'(HOUR12_MIN);
            end else begin
                adv_hour = hour_q + 8'd1;
                if (hour_q == 8'd11) adv_ampm = ~ampm_q;
            end
        end

        sec_d  = sec_ok  ? set_data : adv_sec;
        min_d  = min_ok  ? set_data : adv_min;
        hour_d = hour_ok ? set_data : adv_hour;
        // A set hour drops the carry, including its AM/PM toggle.
        if (MODE_24H != 0)
            ampm_d = (hour_d >= 8'd12);
        else if (ampm_ok)
            ampm_d = set_data[0];
        else
            ampm_d = hour_ok ? ampm_q : adv_ampm;

        for (int i = 0; i < NUM_ALARMS; i++) begin
            fire_d[i] = carry_min && !any_set && alarm_q[i].en
                     && ({3'b000, alarm_q[i].hour} == adv_hour)
                     && (alarm_q[i].min == adv_min)
                     && ((MODE_24H != 0) || (alarm_q[i].ampm == adv_ampm));
        end

        for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_d[i] = alarm_q[i];
            if (alarm_wr && (alarm_sel == SEL_W'(i)))
                alarm_d[i] = alarm_t'(alarm_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= HOUR_RST;
            ampm_q <= 1'b0;
            tick_q <= 1'b0;
            fire_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            ampm_q <= ampm_d;
            tick_q <= tick;
            fire_q <= fire_d;
            for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= alarm_d[i];
        end
    end

`ifdef RTC_UPTIME_EN
    logic [31:0] up_q, up_d;

    always_comb begin
        up_d = up_q;
        if (tick) up_d = up_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) up_q <= '0;
        else       up_q <= up_d;
    end

    assign uptime = up_q;
`else
    assign uptime = 32'd0;
`endif

    assign hour       = hour_q;
    assign minute     = min_q;
    assign second     = sec_q;
    assign ampm       = ampm_q;
    assign sec_tick   = tick_q;
    assign alarm_fire = fire_q;

endmodule

// File: tb/tb_feed_rtc.sv
// Bench for feed_rtc: 12 h and 24 h instances against a seconds-of-day model.
// Directed corner cases first, then randomized set/alarm episodes.
module tb_feed_rtc;

    localparam int HZ = 4;
    localparam int NA = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_hour = 0, set_min = 0, set_sec = 0, set_ampm = 0;
    logic [7:0]  set_data = '0;
    logic        alarm_wr = 0;
    logic [1:0]  alarm_sel = '0;
    logic [14:0] alarm_data = '0;

    logic [7:0]  h12, m12, s12, h24, m24, s24;
    logic        ap12, tk12, ap24, tk24;
    logic [3:0]  f12, f24;
    logic [31:0] up12, up24;

    always #5 clk = ~clk;

    feed_rtc #(.CLK_HZ(HZ), .NUM_ALARMS(NA), .MODE_24H(0)) u12 (
        .clk(clk), .reset(reset),
        .set_hour(set_hour), .set_min(set_min),
        .set_sec(set_sec), .set_ampm(set_ampm), .set_data(set_data),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_data(alarm_data),
        .hour(h12), .minute(m12), .second(s12), .ampm(ap12),
        .sec_tick(tk12), .alarm_fire(f12), .uptime(up12)
    );

    feed_rtc #(.CLK_HZ(HZ), .NUM_ALARMS(NA), .MODE_24H(1)) u24 (
        .clk(clk), .reset(reset),
        .set_hour(set_hour), .set_min(set_min),
        .set_sec(set_sec), .set_ampm(set_ampm), .set_data(set_data),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_data(alarm_data),
        .hour(h24), .minute(m24), .second(s24), .ampm(ap24),
        .sec_tick(tk24), .alarm_fire(f24), .uptime(up24)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: time of day as seconds since midnight.
    int   t [2];
    int   pc [2];
    int   up [2];
    bit   tk_e [2];
    logic [3:0] fire_e [2];
    bit   a_en [NA];
    bit   a_ap [NA];
    int   a_h [NA];
    int   a_m [NA];

    function automatic int disp(input int h24v, input bit mz);
        if (mz) return h24v;
        return (h24v % 12 == 0) ? 12 : h24v % 12;
    endfunction

    task automatic model_step(input int m);
        bit mz, tk, ap, vs, vm, vh, va;
        int adv, h, mi, s, oh, d, hh;
        mz = (m == 1);
        d = int'(set_data);
        if (reset) begin
            t[m] = 0; pc[m] = 0; up[m] = 0;
            tk_e[m] = 0; fire_e[m] = '0;
            return;
        end
        tk = (pc[m] == HZ - 1);
        adv = tk ? (t[m] + 1) % 86400 : t[m];
        h = adv / 3600; mi = (adv / 60) % 60; s = adv % 60;
        oh = t[m] / 3600;
        vs = set_sec && d <= 59;
        vm = set_min && d <= 59;
        vh = set_hour && (mz ? d <= 23 : (d >= 1 && d <= 12));
        va = set_ampm && !mz;
        fire_e[m] = '0;
        if (tk && s == 0 && !(vs || vm || vh || va))
            for (int c = 0; c < NA; c++)
                if (a_en[c] && a_m[c] == mi && a_h[c] == disp(h, mz)
                    && (mz || a_ap[c] == (h >= 12)))
                    fire_e[m][c] = 1'b1;
        if (vs) s = d;
        if (vm) mi = d;
        if (mz) begin
            if (vh) h = d;
        end else begin
            ap = va ? set_data[0] : (vh ? (oh >= 12) : (h >= 12));
            hh = vh ? d : disp(h, 1'b0);
            h = (hh % 12) + (ap ? 12 : 0);
        end
        t[m] = h * 3600 + mi * 60 + s;
        pc[m] = (vs || tk) ? 0 : pc[m] + 1;
        up[m] = up[m] + (tk ? 1 : 0);
        tk_e[m] = tk;
    endtask

    function automatic logic [61:0] expv(input int m);
        int hv;
        logic [31:0] ue;
        hv = t[m] / 3600;
`ifdef RTC_UPTIME_EN
        ue = 32'(up[m]);
`else
        ue = 32'd0;
`endif
        return {8'(disp(hv, m == 1)), 8'((t[m] / 60) % 60), 8'(t[m] % 60),
                hv >= 12, tk_e[m], fire_e[m], ue};
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (reset) begin
            for (int c = 0; c < NA; c++) begin
                a_en[c] = 0; a_ap[c] = 0; a_h[c] = 0; a_m[c] = 0;
            end
        end else if (alarm_wr) begin
            a_en[alarm_sel] = alarm_data[14];
            a_ap[alarm_sel] = alarm_data[13];
            a_h[alarm_sel]  = int'(alarm_data[12:8]);
            a_m[alarm_sel]  = int'(alarm_data[7:0]);
        end
        #2;
        check("cyc12", {h12, m12, s12, ap12, tk12, f12, up12}, expv(0));
        check("cyc24", {h24, m24, s24, ap24, tk24, f24, up24}, expv(1));
    end

    // Caller sits at a negedge; strobe is seen at the next posedge.
    task automatic put(input int kind, input int d);
        set_data = 8'(d);
        case (kind)
            0: set_hour = 1'b1;
            1: set_min  = 1'b1;
            2: set_sec  = 1'b1;
            default: set_ampm = 1'b1;
        endcase
        @(negedge clk);
        set_hour = 0; set_min = 0; set_sec = 0; set_ampm = 0;
    endtask

    task automatic awr(input int sel, input logic [14:0] d);
        alarm_wr = 1'b1;
        alarm_sel = 2'(sel);
        alarm_data = d;
        @(negedge clk);
        alarm_wr = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s,
                            input int ap);
        put(2, 0);
        put(0, h);
        put(1, m);
        put(3, ap);
        put(2, s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nt, k, v, mi, ap, ch, r;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_time12", {h12, m12, s12, ap12}, {8'd12, 8'd0, 8'd0, 1'b0});
        check("rst_hour24", h24, 8'd0);
        check("rst_fire", {f12, f24}, 8'd0);

        nt = 0;
        repeat (4) begin
            @(posedge clk); #2;
            nt += int'(tk12);
        end
        check("boot_ticks", nt, 1);
        check("boot_sec", s12, 8'd1);
        @(negedge clk);

        set_time(11, 59, 59, 0);
        repeat (4) @(posedge clk); #2;
        check("noon_roll", {h12, m12, s12, ap12}, {8'd12, 8'd0, 8'd0, 1'b1});
        @(negedge clk);

        set_time(12, 59, 59, 1);
        repeat (4) @(posedge clk); #2;
        check("pm1_roll", {h12, m12, s12, ap12}, {8'd1, 8'd0, 8'd0, 1'b1});
        @(negedge clk);

        set_time(23, 59, 59, 0);
        repeat (4) @(posedge clk); #2;
        check("midnight24", {h24, m24, s24, ap24}, {8'd0, 8'd0, 8'd0, 1'b0});
        @(negedge clk);
        put(0, 24);
        check("bad_hour24", h24, 8'd0);

        awr(2, {1'b1, 1'b1, 5'd7, 8'd30});
        set_time(7, 29, 59, 1);
        repeat (4) @(posedge clk); #2;
        check("alarm12", f12, 4'b0100);
        check("alarm24", f24, 4'b0100);
        @(posedge clk); #2;
        check("alarm_once", {f12, f24}, 8'd0);
        @(negedge clk);

        awr(2, {1'b0, 1'b1, 5'd7, 8'd30});
        set_time(7, 29, 59, 1);
        repeat (4) @(posedge clk); #2;
        check("alarm_off", {f12, f24}, 8'd0);
        @(negedge clk);

        set_time(3, 10, 59, 0);
        repeat (3) @(negedge clk);
        put(1, 5);
        check("min_set_carry", {h12, m12, s12}, {8'd3, 8'd5, 8'd0});

        repeat (2) @(negedge clk);
        put(2, 0);
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (!tk12 && k < 10);
        check("presc_clear", k, 4);
        @(negedge clk);

        do_reset();
        check("rst_uptime", up12, 32'd0);
        repeat (40) @(posedge clk); #2;
`ifdef RTC_UPTIME_EN
        check("uptime10", up12, 32'd10);
`else
        check("uptime_off", up12, 32'd0);
`endif
        @(negedge clk);

        for (int ep = 0; ep < 60; ep++) begin
            v  = $urandom_range(1, 11);
            mi = $urandom_range(0, 58);
            ap = $urandom_range(0, 1);
            ch = $urandom_range(0, 3);
            awr(ch, {($urandom_range(0, 3) != 0), 1'(ap), 5'(v), 8'(mi + 1)});
            set_time(v, mi, 59, ap);
            repeat (8) begin
                r = $urandom_range(0, 15);
                if (r < 4)
                    put(r, $urandom_range(0, 70));
                else if (r == 4)
                    awr($urandom_range(0, 3), 15'($urandom));
                else if (r == 15 && $urandom_range(0, 9) == 0)
                    do_reset();
                else
                    @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
